// File: rtl/game_referee.sv
// game_referee: round controller for the gravity-runner game.
// Runs the lobby (players join), the start countdown and live play, and
// eliminates players whose sprite stays outside the playfield too long.
//
// Optional feature macro: GAME_REFEREE_SCORE_EN builds the survival score
// prescaler and counter; when undefined score_o is tied to 0.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-low reset
//   new_game_i     debounced new-game button (level)
//   join_i[3:0]    debounced per-player join buttons (level)
//   pN_loc_i[8:0]  player N sprite top-edge y location
//   player_en_o    joined / still-alive players
//   state_o        0 LOBBY, 1 COUNTDOWN, 2 PLAY, 3 OVER
//   play_o         high in PLAY
//   winner_o       winning player set, valid in OVER
//   winner_valid_o high in OVER
//   score_o        survival score of the current or last round
module game_referee #(
    parameter int unsigned WindowHeight    = 480,
    parameter int unsigned PlayerHeight    = 40,
    parameter int unsigned OutLow          = 2,
    parameter int unsigned OutHoldCycles   = 1_000_000,
    parameter int unsigned CountdownCycles = 300_000_000,
    parameter int unsigned ScoreDiv        = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        new_game_i,
    input  logic [3:0]  join_i,
    input  logic [8:0]  p0_loc_i,
    input  logic [8:0]  p1_loc_i,
    input  logic [8:0]  p2_loc_i,
    input  logic [8:0]  p3_loc_i,
    output logic [3:0]  player_en_o,
    output logic [1:0]  state_o,
    output logic        play_o,
    output logic [3:0]  winner_o,
    output logic        winner_valid_o,
    output logic [15:0] score_o
);

    localparam int unsigned NumPlayers = 4;
    localparam int unsigned LocW       = 9;
    localparam int unsigned OutCntW    = 20;
    localparam int unsigned CdCntW     = 32;
    localparam int unsigned StartW     = 3;

    localparam logic [LocW-1:0]    OutHighThr = LocW'(WindowHeight - PlayerHeight);
    localparam logic [LocW-1:0]    OutLowThr  = LocW'(OutLow);
    localparam logic [OutCntW-1:0] OutLast    = OutCntW'(OutHoldCycles - 1);
    localparam logic [CdCntW-1:0]  CdLast     = CdCntW'(CountdownCycles - 1);

    localparam logic [1:0] StLobby     = 2'd0;
    localparam logic [1:0] StCountdown = 2'd1;
    localparam logic [1:0] StPlay      = 2'd2;
    localparam logic [1:0] StOver      = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [NumPlayers-1:0] en_q, en_d;
    logic [NumPlayers-1:0] win_q, win_d;
    logic [StartW-1:0]     start_q, start_d;
    logic [CdCntW-1:0]     cd_q, cd_d;
    logic [OutCntW-1:0]    ocnt_q [NumPlayers];
    logic [OutCntW-1:0]    ocnt_d [NumPlayers];

    logic                  ng_s_q, ng_p_q;
    logic [NumPlayers-1:0] jn_s_q, jn_p_q;
    logic                  ng_rise;
    logic [NumPlayers-1:0] join_rise;

    logic [LocW-1:0]       loc [NumPlayers];
    logic [NumPlayers-1:0] out_now;
    logic [StartW-1:0]     remain;

    function automatic logic [StartW-1:0] popcnt4(input logic [NumPlayers-1:0] v);
        logic [StartW-1:0] c;
        c = '0;
        for (int i = 0; i < NumPlayers; i++) begin
            c = c + StartW'(v[i]);
        end
        return c;
    endfunction

    // Button rise detection on the once-registered samples
    assign ng_rise   = ng_s_q & ~ng_p_q;
    assign join_rise = jn_s_q & ~jn_p_q;

    // Per-player out-of-bounds decode
    always_comb begin
        loc[0] = p0_loc_i;
        loc[1] = p1_loc_i;
        loc[2] = p2_loc_i;
        loc[3] = p3_loc_i;
        out_now = '0;
        for (int i = 0; i < NumPlayers; i++) begin
            out_now[i] = (loc[i] < OutLowThr) || (loc[i] >= OutHighThr);
        end
    end

    // Next-state and round bookkeeping
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        win_d   = win_q;
        start_d = start_q;
        cd_d    = cd_q;
        ocnt_d  = ocnt_q;
        remain  = '0;

        case (state_q)
            StLobby: begin
                // Joins on the start edge are dropped so start_count matches player_en_o
                if (ng_rise && (en_q != '0)) begin
                    state_d = StCountdown;
                    start_d = popcnt4(en_q);
                    cd_d    = '0;
                end else begin
                    en_d = en_q | join_rise;
                end
            end

            StCountdown: begin
                if (cd_q == CdLast) begin
                    state_d = StPlay;
                    cd_d    = '0;
                    for (int i = 0; i < NumPlayers; i++) begin
                        ocnt_d[i] = '0;
                    end
                end else begin
                    cd_d = cd_q + CdCntW'(1);
                end
            end

            StPlay: begin
                for (int i = 0; i < NumPlayers; i++) begin
                    if (en_q[i]) begin
                        if (out_now[i]) begin
                            if (ocnt_q[i] == OutLast) begin
                                en_d[i]   = 1'b0;
                                ocnt_d[i] = '0;
                            end else begin
                                ocnt_d[i] = ocnt_q[i] + OutCntW'(1);
                            end
                        end else begin
                            ocnt_d[i] = '0;
                        end
                    end
                end
                // End condition looks at the enables after this edge's eliminations
                remain = popcnt4(en_d);
                if (((start_q > StartW'(1)) && (remain <= StartW'(1))) ||
                    ((start_q == StartW'(1)) && (remain == '0))) begin
                    state_d = StOver;
                    win_d   = (remain == StartW'(1)) ? en_d : (en_q & ~en_d);
                end
            end

            StOver: begin
                if (ng_rise) begin
                    state_d = StLobby;
                    en_d    = '0;
                    win_d   = '0;
                    start_d = '0;
                    cd_d    = '0;
                    for (int i = 0; i < NumPlayers; i++) begin
                        ocnt_d[i] = '0;
                    end
                end
            end

            default: state_d = StLobby;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StLobby;
            en_q    <= '0;
            win_q   <= '0;
            start_q <= '0;
            cd_q    <= '0;
            ng_s_q  <= 1'b0;
            ng_p_q  <= 1'b0;
            jn_s_q  <= '0;
            jn_p_q  <= '0;
            for (int i = 0; i < NumPlayers; i++) begin
                ocnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            win_q   <= win_d;
            start_q <= start_d;
            cd_q    <= cd_d;
            ng_s_q  <= new_game_i;
            ng_p_q  <= ng_s_q;
            jn_s_q  <= join_i;
            jn_p_q  <= jn_s_q;
            for (int i = 0; i < NumPlayers; i++) begin
                ocnt_q[i] <= ocnt_d[i];
            end
        end
    end

    assign player_en_o    = en_q;
    assign state_o        = state_q;
    assign winner_o       = win_q;
    assign play_o         = (state_q == StPlay);
    assign winner_valid_o = (state_q == StOver);

`ifdef GAME_REFEREE_SCORE_EN
    localparam int unsigned ScoreW = 16;
    localparam int unsigned PreW   = (ScoreDiv > 1) ? $clog2(ScoreDiv) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(ScoreDiv - 1);

    logic [PreW-1:0]   pre_q, pre_d;
    logic [ScoreW-1:0] score_q, score_d;

    // Survival score: prescaled PLAY-cycle count, saturating
    always_comb begin
        pre_d   = pre_q;
        score_d = score_q;
        if ((state_q == StCountdown) && (state_d == StPlay)) begin
            pre_d   = '0;
            score_d = '0;
        end else if (state_q == StPlay) begin
            if (pre_q == PreLast) begin
                pre_d = '0;
                if (score_q != {ScoreW{1'b1}}) begin
                    score_d = score_q + ScoreW'(1);
                end
            end else begin
                pre_d = pre_q + PreW'(1);
            end
        end else if ((state_q == StOver) && (state_d == StLobby)) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pre_q   <= '0;
            score_q <= '0;
        end else begin
            pre_q   <= pre_d;
            score_q <= score_d;
        end
    end

    assign score_o = score_q;
`else
    assign score_o = '0;
`endif

endmodule

// File: doc/game_referee.md
# game_referee

Round controller for the gravity-runner game. It runs the lobby where players join, the start countdown and live play, and eliminates players whose sprite leaves the playfield. It produces `PLAYER_EN` for the player generators and renderers, and it consumes the per-player vertical locations those generators produce. Outputs are registered, so the display and player logic see stable enables for a whole frame.

## Interface
Parameters:
- `WindowHeight`, default 480: playfield height in pixels.
- `PlayerHeight`, default 40: sprite height in pixels. The out-of-bounds high threshold is `WindowHeight - PlayerHeight`.
- `OutLow`, default 2: a `loc` value below this is out of bounds at the top.
- `OutHoldCycles`, default 1_000_000: consecutive out-of-bounds cycles required before elimination. Minimum 1; counter is 20 bits.
- `CountdownCycles`, default 300_000_000: length of COUNTDOWN in cycles. Counter is 32 bits.
- `ScoreDiv`, default 1_000_000: clock cycles per score unit.

Ports:
- `clk_i`, in, 1: system clock.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `new_game_i`, in, 1: debounced new-game button, level.
- `join_i`, in, 4: debounced per-player join buttons (the gravity buttons), level.
- `p0_loc_i` … `p3_loc_i`, in, 9 each: player top-edge y location, unsigned.
- `player_en_o`, out, 4: active/joined players.
- `state_o`, out, 2: 0 LOBBY, 1 COUNTDOWN, 2 PLAY, 3 OVER.
- `play_o`, out, 1: high while in PLAY.
- `winner_o`, out, 4: one-hot, or multi-hot on a tie. Valid in OVER.
- `winner_valid_o`, out, 1: high in OVER.
- `score_o`, out, 16: survival score of the current or last round.

## Operation
- Reset values: state LOBBY; every output 0; all internal counters 0; edge-detect history 0.
- Edge detection:
  - `new_game_i` and `join_i` are registered once.
  - A rise is `sampled & ~prev`.
  - Holding a button produces one event only.
- LOBBY:
  - A rise on `join_i[n]` sets `player_en_o[n]`. Further rises have no effect; there is no un-join.
  - A rise on `new_game_i` with `player_en_o != 0` moves to COUNTDOWN and records `start_count = popcount(player_en_o)`.
  - A rise on `new_game_i` with no players joined is ignored.
- COUNTDOWN:
  - Counts `CountdownCycles`, then moves to PLAY.
  - `join_i` and `new_game_i` are ignored.
  - On entry to PLAY, `score_o` clears.
- PLAY:
  - Player n is out when `p_loc < OutLow` or `p_loc >= WindowHeight - PlayerHeight`. Comparisons are 9-bit unsigned.
  - Each enabled player has an out counter. It increments on each cycle the player is out and clears on any cycle the player is back in.
  - When the counter reaches `OutHoldCycles-1` while still out, `player_en_o[n]` clears on that edge.
  - Disabled players are never evaluated.
  - End condition is evaluated on the enables after the update:
    - If `start_count > 1` and one or zero players remain → OVER.
    - If `start_count == 1` and zero players remain → OVER.
  - Winner:
    - If one player remains, `winner_o` is that player's bit.
    - If zero remain, `winner_o` is the set of players eliminated on that final edge. This covers both the tie case and single-player mode.
  - `new_game_i` is ignored.
- OVER:
  - `winner_o`, `score_o` and `player_en_o` are frozen.
  - A rise on `new_game_i` returns to LOBBY. The same edge clears `player_en_o`, `winner_o`, `winner_valid_o` and all counters. `score_o` is kept until the next PLAY entry.
- Score:
  - A prescaler counts `ScoreDiv` cycles in PLAY only.
  - Each wrap adds 1 to `score_o`, which saturates at 0xFFFF.

## Timing
- Button latency:
  - A button first sampled high at edge k is registered at edge k.
  - Its effect (enable set, state change) is visible after edge k+1.
- Elimination:
  - A player first out at edge k has its enable cleared at edge k+OutHoldCycles-1, provided it stays out continuously.
  - With `OutHoldCycles = 1`, elimination happens at edge k.
- State transitions:
  - COUNTDOWN entered at edge e → `state_o == 2` after edge e+CountdownCycles.
  - The transition to OVER, `winner_valid_o`, and the final `player_en_o` all update on the same edge.
- Reset mid-round returns to LOBBY immediately (asynchronous), with all outputs 0.
- `play_o` and `winner_valid_o` are decoded from the state register, with no extra latency.

## Configuration
- `GAME_REFEREE_SCORE_EN` defined:
  - Prescaler and 16-bit saturating score counter are built.
  - `score_o` behaves as specified above.
- `GAME_REFEREE_SCORE_EN` undefined:
  - No score logic is built.
  - `score_o` is tied to 0.
  - All other behaviour is identical.

## Test plan
Bench parameters: `OutHoldCycles=4`, `CountdownCycles=10`, `ScoreDiv=5`.

1. Join and start:
   - Stimulus: rises on `join_i` bits 0 and 2, then `new_game_i` held high 20 cycles.
   - Required: `player_en_o=4'b0101`; `state_o` goes 0→1→2; entry to PLAY is exactly 10 cycles after entering COUNTDOWN; the held button causes no second event.
2. Empty lobby:
   - Stimulus: `new_game_i` rise with no joins.
   - Required: stays in LOBBY with `player_en_o=0`.
3. Out hold:
   - Stimulus: `p0_loc=445` for 3 cycles, 200 for 1 cycle, then 445 for 4 cycles.
   - Required: no elimination on the first excursion; `player_en_o[0]` clears on the 4th out cycle of the second excursion. Then `state_o=3` and `winner_o=4'b0100`.
4. Tie:
   - Stimulus: players 1 and 3 only; both set to `loc=0` on the same cycle.
   - Required: both enables clear on the same edge; `winner_o=4'b1010`; `winner_valid_o=1`.
5. Single player and score:
   - Stimulus: only player 2 joined; stays in bounds for 52 PLAY cycles, then goes out.
   - Required: `score_o` reaches 10 by cycle 52; after elimination, `winner_o=4'b0100`.
6. Async reset in PLAY:
   - Stimulus: `rst_i` low mid-cycle during PLAY.
   - Required: all outputs 0 and state 0 before the next clock edge.
